// File: rtl/riscv_exc_controller.sv
// riscv_exc_controller: prioritises exceptions/interrupts and sequences PC redirects for trap entry and mret
module riscv_exc_controller #(
   parameter int IRQ_ID_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_load_err_i,
   input  logic                req_store_err_i,
   input  logic                req_illegal_i,
   input  logic                req_ecall_i,
   input  logic                req_ebreak_i,
   input  logic                irq_i,
   input  logic [IRQ_ID_W-1:0] irq_id_i,
   input  logic                irq_enable_i,
   input  logic                mret_i,
   input  logic                lsu_busy_i,
   output logic                halt_id_o,
   output logic                pc_set_o,
   output logic [2:0]          pc_mux_o,
   output logic [2:0]          exc_pc_mux_o,
   output logic [7:0]          exc_vec_off_o,
   output logic                save_epc_o,
   output logic [5:0]          exc_cause_o,
   output logic                irq_ack_o,
   output logic [IRQ_ID_W-1:0] irq_ack_id_o,
   output logic                in_irq_o
);
   localparam logic [1:0] IDLE = 2'd0, FLUSH = 2'd1, SET_EXC = 2'd2, SET_ERET = 2'd3;
   logic [1:0]          state;
   logic [5:0]          cause_q, cause_d;
   logic [2:0]          mux_q, mux_d;
   logic [7:0]          off_q, off_d;
   logic [IRQ_ID_W-1:0] id_q;
   logic                irq_q, in_irq_q, irq_pend, exc_any, take;
   logic [4:0]          id5;
   assign id5      = 5'(irq_id_i);
   assign irq_pend = irq_i && irq_enable_i && !in_irq_q;
   assign exc_any  = req_load_err_i || req_store_err_i || req_illegal_i || req_ecall_i || req_ebreak_i;
   assign take     = exc_any || irq_pend;
   always_comb begin
      cause_d = req_load_err_i  ? 6'h05 :
                req_store_err_i ? 6'h07 :
                req_illegal_i   ? 6'h02 :
                req_ecall_i     ? 6'h0B :
                req_ebreak_i    ? 6'h03 : {1'b1, id5};
      mux_d   = req_load_err_i  ? 3'b011 :
                req_store_err_i ? 3'b100 :
                req_illegal_i   ? 3'b000 :
                req_ecall_i     ? 3'b001 :
                req_ebreak_i    ? 3'b010 : 3'b101;
      off_d   = (req_load_err_i || req_store_err_i) ? 8'h8C :
                req_illegal_i                       ? 8'h84 :
                (req_ecall_i || req_ebreak_i)       ? 8'h88 : {id5, 2'b00};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cause_q  <= '0;
         mux_q    <= '0;
         off_q    <= '0;
         id_q     <= '0;
         irq_q    <= 1'b0;
         in_irq_q <= 1'b0;
      end else if (state == IDLE && take) begin
         state   <= FLUSH;
         cause_q <= cause_d;
         mux_q   <= mux_d;
         off_q   <= off_d;
         id_q    <= irq_id_i;
         irq_q   <= !exc_any;
      end else if (state == IDLE && mret_i) begin
         state <= SET_ERET;
      end else if (state == FLUSH && !lsu_busy_i) begin
         state <= SET_EXC;
      end else if (state == SET_EXC) begin
         state <= IDLE;
         if (irq_q) in_irq_q <= 1'b1;
      end else if (state == SET_ERET) begin
         state    <= IDLE;
         in_irq_q <= 1'b0;
      end
   end
   assign halt_id_o     = state == FLUSH || state == SET_EXC;
   assign pc_set_o      = state == SET_EXC || state == SET_ERET;
   assign pc_mux_o      = state == SET_EXC ? 3'b100 : state == SET_ERET ? 3'b101 : 3'b000;
   assign exc_pc_mux_o  = state == SET_EXC ? mux_q : 3'b000;
   assign exc_vec_off_o = off_q;
   assign exc_cause_o   = cause_q;
   assign save_epc_o    = state == SET_EXC;
   assign irq_ack_o     = state == SET_EXC && irq_q;
   assign irq_ack_id_o  = irq_ack_o ? id_q : '0;
   assign in_irq_o      = in_irq_q;
endmodule

// File: tb/tb_riscv_exc_controller.sv
// tb_riscv_exc_controller: directed vector table plus hand sequences for stall, mret and reset-abort
module tb_riscv_exc_controller;
   logic       clk = 1'b0, rst = 1'b1;
   logic       ld = 0, st = 0, ill = 0, ec = 0, eb = 0, irq = 0, en = 0, mret = 0, busy = 0;
   logic [4:0] id = '0;
   logic       halt, pc_set, save_epc, ack, in_irq;
   logic [2:0] pc_mux, exc_mux;
   logic [7:0] off;
   logic [5:0] cause;
   logic [4:0] ack_id;
   int total = 0, bad = 0;

   riscv_exc_controller #(.IRQ_ID_W(5)) dut (
      .clk(clk), .rst(rst),
      .req_load_err_i(ld), .req_store_err_i(st), .req_illegal_i(ill),
      .req_ecall_i(ec), .req_ebreak_i(eb),
      .irq_i(irq), .irq_id_i(id), .irq_enable_i(en),
      .mret_i(mret), .lsu_busy_i(busy),
      .halt_id_o(halt), .pc_set_o(pc_set), .pc_mux_o(pc_mux),
      .exc_pc_mux_o(exc_mux), .exc_vec_off_o(off), .save_epc_o(save_epc),
      .exc_cause_o(cause), .irq_ack_o(ack), .irq_ack_id_o(ack_id), .in_irq_o(in_irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] req;
      logic [4:0] id;
      int         kind;
      logic [5:0] cause;
      logic [2:0] mux;
      logic [7:0] off;
      logic       ack;
      logic       in_irq_after;
   } vec_t;

   vec_t v[12];

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_reqs;
      {ld, st, ill, ec, eb, irq, en, mret} = '0;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, " halt"}, halt, 0);
      chk({tag, " pc_set"}, pc_set, 0);
      chk({tag, " pc_mux"}, pc_mux, 0);
      chk({tag, " exc_mux"}, exc_mux, 0);
      chk({tag, " off"}, off, 0);
      chk({tag, " cause"}, cause, 0);
      chk({tag, " save_epc"}, save_epc, 0);
      chk({tag, " ack"}, ack, 0);
      chk({tag, " ack_id"}, ack_id, 0);
      chk({tag, " in_irq"}, in_irq, 0);
   endtask

   initial begin
      // req = {ld, st, ill, ec, eb, irq, en, mret, unused}; kind 0=exception, 1=eret, 2=nothing taken
      v[0]  = '{9'b001000000, 5'd0,  0, 6'h02, 3'b000, 8'h84, 0, 0};
      v[1]  = '{9'b100101100, 5'd6,  0, 6'h05, 3'b011, 8'h8C, 0, 0};
      v[2]  = '{9'b011000000, 5'd0,  0, 6'h07, 3'b100, 8'h8C, 0, 0};
      v[3]  = '{9'b000110000, 5'd0,  0, 6'h0B, 3'b001, 8'h88, 0, 0};
      v[4]  = '{9'b000010010, 5'd0,  0, 6'h03, 3'b010, 8'h88, 0, 0};
      v[5]  = '{9'b000001100, 5'd9,  0, 6'h29, 3'b101, 8'h24, 1, 1};
      v[6]  = '{9'b000001100, 5'd3,  2, 6'h00, 3'b000, 8'h00, 0, 1};
      v[7]  = '{9'b001000000, 5'd0,  0, 6'h02, 3'b000, 8'h84, 0, 1};
      v[8]  = '{9'b000000010, 5'd0,  1, 6'h00, 3'b000, 8'h00, 0, 0};
      v[9]  = '{9'b000001000, 5'd3,  2, 6'h00, 3'b000, 8'h00, 0, 0};
      v[10] = '{9'b000001100, 5'd31, 0, 6'h3F, 3'b101, 8'h7C, 1, 1};
      v[11] = '{9'b000001110, 5'd2,  1, 6'h00, 3'b000, 8'h00, 0, 0};

      tick;
      tick;
      rst = 1'b0;
      all_zero("reset");

      foreach (v[i]) begin
         {ld, st, ill, ec, eb, irq, en, mret} = v[i].req[8:1];
         id = v[i].id;
         tick;
         clear_reqs;
         chk($sformatf("v%0d s1 halt", i), halt, v[i].kind == 0);
         chk($sformatf("v%0d s1 pc_set", i), pc_set, v[i].kind == 1);
         chk($sformatf("v%0d s1 pc_mux", i), pc_mux, v[i].kind == 1 ? 3'b101 : 3'b000);
         tick;
         chk($sformatf("v%0d s2 pc_set", i), pc_set, v[i].kind == 0);
         chk($sformatf("v%0d s2 pc_mux", i), pc_mux, v[i].kind == 0 ? 3'b100 : 3'b000);
         chk($sformatf("v%0d s2 save_epc", i), save_epc, v[i].kind == 0);
         chk($sformatf("v%0d s2 exc_mux", i), exc_mux, v[i].kind == 0 ? v[i].mux : 3'b000);
         chk($sformatf("v%0d s2 ack", i), ack, v[i].kind == 0 && v[i].ack);
         chk($sformatf("v%0d s2 ack_id", i), ack_id, (v[i].kind == 0 && v[i].ack) ? v[i].id : 5'd0);
         if (v[i].kind == 0) begin
            chk($sformatf("v%0d s2 cause", i), cause, v[i].cause);
            chk($sformatf("v%0d s2 off", i), off, v[i].off);
            chk($sformatf("v%0d s2 halt", i), halt, 1);
         end
         tick;
         chk($sformatf("v%0d s3 in_irq", i), in_irq, v[i].in_irq_after);
         chk($sformatf("v%0d s3 halt", i), halt, 0);
         chk($sformatf("v%0d s3 pc_set", i), pc_set, 0);
      end

      // irq held off by a busy LSU: busy in the request cycle and two FLUSH cycles
      begin
         int halts = 0;
         irq = 1; en = 1; id = 5'd7; busy = 1;
         tick;
         clear_reqs;
         for (int k = 0; k < 2; k++) begin
            halts += halt;
            chk("busy flush pc_set", pc_set, 0);
            tick;
         end
         busy = 0;
         halts += halt;
         chk("busy last flush pc_set", pc_set, 0);
         tick;
         halts += halt;
         chk("busy exc pc_set", pc_set, 1);
         chk("busy exc cause", cause, 6'h27);
         chk("busy exc off", off, 8'h1C);
         chk("busy exc mux", exc_mux, 3'b101);
         chk("busy exc ack", ack, 1);
         chk("busy exc ack_id", ack_id, 7);
         chk("busy exc in_irq", in_irq, 0);
         tick;
         chk("busy halt count", halts, 4);
         chk("busy in_irq after", in_irq, 1);
         chk("busy halt after", halt, 0);
      end

      // nested irq ignored while in handler
      irq = 1; en = 1; id = 5'd2;
      tick;
      chk("nested irq halt", halt, 0);
      chk("nested irq pc_set", pc_set, 0);
      tick;
      chk("nested irq halt2", halt, 0);
      // mret with the irq still asserted: mret wins since irq is masked by in_irq
      mret = 1;
      tick;
      clear_reqs;
      chk("mret pc_set", pc_set, 1);
      chk("mret pc_mux", pc_mux, 3'b101);
      chk("mret ack", ack, 0);
      tick;
      chk("mret in_irq cleared", in_irq, 0);
      chk("mret pc_set after", pc_set, 0);

      // reset in FLUSH aborts the trap and clears handler state
      irq = 1; en = 1; id = 5'd4;
      tick;
      clear_reqs;
      tick;
      tick;
      chk("pre-reset in_irq", in_irq, 1);
      ill = 1; busy = 1;
      tick;
      clear_reqs;
      chk("pre-reset flush halt", halt, 1);
      rst = 1;
      tick;
      rst = 0; busy = 0;
      all_zero("rst flush");
      tick;
      chk("post-reset pc_set", pc_set, 0);
      chk("post-reset halt", halt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/riscv_exc_controller.md
RISCV_EXC_CONTROLLER -- requirements
Module: riscv_exc_controller

Interface
REQ-001 SHALL have parameter IRQ_ID_W, default 5, meaning width of the external interrupt ID.
REQ-002 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req_load_err_i, req_store_err_i, req_illegal_i, req_ecall_i, req_ebreak_i  input  1 each  synchronous exception requests.
REQ-005 SHALL have ports irq_i  input  1  interrupt request; irq_id_i  input  IRQ_ID_W  interrupt ID; irq_enable_i  input  1  global interrupt enable.
REQ-006 SHALL have ports mret_i  input  1  return-from-handler request; lsu_busy_i  input  1  outstanding data transaction.
REQ-007 SHALL have port halt_id_o  output  1  stalls decode/fetch while an exception is being sequenced.
REQ-008 SHALL have ports pc_set_o  output  1  PC load strobe; pc_mux_o  output  3  PC mux select, PC_EXCEPTION=3'b100 or PC_ERET=3'b101.
REQ-009 SHALL have ports exc_pc_mux_o  output  3  exception PC select; exc_vec_off_o  output  8  vector offset.
REQ-010 SHALL have ports save_epc_o  output  1  EPC/cause capture strobe; exc_cause_o  output  6  cause code, bit 5 set for interrupts.
REQ-011 SHALL have ports irq_ack_o  output  1  interrupt acknowledge; irq_ack_id_o  output  IRQ_ID_W  acknowledged ID; in_irq_o  output  1  interrupt handler active.

Function
REQ-012 SHALL implement FSM states IDLE, FLUSH, SET_EXC, SET_ERET.
REQ-013 SHALL, in IDLE, arbitrate by fixed priority: load_err > store_err > illegal > ecall > ebreak > irq.
REQ-014 SHALL treat irq as pending only when irq_i && irq_enable_i && !in_irq_o.
REQ-015 SHALL, on any winning request in IDLE, latch cause, exc_pc_mux, vector offset and irq ID, then move to FLUSH.
REQ-016 SHALL use these cause/exc_pc_mux/offset values:
- load_err: 6'h05 / EXC_PC_LOAD 3'b011 / 8'h8C
- store_err: 6'h07 / EXC_PC_STORE 3'b100 / 8'h8C
- illegal: 6'h02 / EXC_PC_ILLINSN 3'b000 / 8'h84
- ecall: 6'h0B / EXC_PC_ECALL 3'b001 / 8'h88
- ebreak: 6'h03 / EXC_PC_EBREAK 3'b010 / 8'h88
- irq: {1'b1, zero-extended irq_id} / EXC_PC_IRQ 3'b101 / {irq_id[4:0], 2'b00}
REQ-017 SHALL assert halt_id_o in FLUSH and SET_EXC, and SHALL stay in FLUSH while lsu_busy_i=1.
REQ-018 SHALL, in FLUSH, move to SET_EXC on the first cycle in which lsu_busy_i=0.
REQ-019 SHALL spend exactly one cycle in SET_EXC with the following, then return to IDLE:
- pc_set_o=1, pc_mux_o=PC_EXCEPTION, save_epc_o=1
- exc_pc_mux_o, exc_vec_off_o and exc_cause_o driven from latched values
REQ-020 SHALL, for an irq winner, also pulse irq_ack_o with irq_ack_id_o in SET_EXC and set in_irq_o from the following cycle.
REQ-021 SHALL, on mret_i in IDLE with no exception or irq winner, move to SET_ERET.
REQ-022 SHALL spend one cycle in SET_ERET with pc_set_o=1 and pc_mux_o=PC_ERET, clear in_irq_o on the following cycle, then return to IDLE.
REQ-023 SHALL give exception and irq winners precedence over a simultaneous mret_i; the mret is dropped.
REQ-024 SHALL ignore all requests and mret_i arriving in FLUSH, SET_EXC and SET_ERET; they are not queued.
REQ-025 SHALL take synchronous exceptions regardless of in_irq_o or irq_enable_i.
REQ-026 SHALL give best-case latency of 2 cycles: request sampled at edge N, pc_set_o high during cycle N+2.
REQ-027 SHALL drive all outputs other than halt_id_o, exc_vec_off_o and exc_cause_o to 0 outside the states where they are asserted; pc_mux_o SHALL be 3'b000 in IDLE and FLUSH.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, enter IDLE, clear all latched values and in_irq_o, and drive every output to 0.
REQ-029 SHALL, on reset asserted in FLUSH/SET_EXC/SET_ERET, abort the sequence with no pc_set_o or irq_ack_o pulse.

Verification
REQ-030 SHALL cover: req_illegal_i pulse in IDLE, lsu_busy_i=0 -> pc_set_o high 2 cycles later with pc_mux_o=3'b100, exc_pc_mux_o=3'b000, exc_cause_o=6'h02, exc_vec_off_o=8'h84.
REQ-031 SHALL cover: req_load_err_i and req_ecall_i in same cycle plus irq_i=1 -> cause 6'h05, exc_pc_mux_o=3'b011, no irq_ack_o.
REQ-032 SHALL cover: irq_i=1, irq_id_i=5'd7, irq_enable_i=1, lsu_busy_i=1 for 3 cycles -> halt_id_o high 4 cycles, then SET_EXC with cause 6'h27, exc_vec_off_o=8'h1C, irq_ack_id_o=7, in_irq_o=1 afterwards; a second irq_i is ignored until mret.
REQ-033 SHALL cover: mret_i in IDLE with in_irq_o=1 -> pc_set_o one cycle later with pc_mux_o=3'b101, in_irq_o=0 the cycle after.
REQ-034 SHALL cover: mret_i coincident with req_ebreak_i -> ebreak taken (cause 6'h03), no PC_ERET strobe.
REQ-035 SHALL cover: rst asserted during FLUSH -> next cycle all outputs 0, state IDLE, no pc_set_o.
